timer_capture: RTL

Input-capture unit: the measuring counterpart of the free-running `timer` block. The timer generates periodic events from a prescaled count. This block receives an external event signal and measures the interval between consecutive selected edges in prescaled ticks. It presents each result to the CPU-side register logic through a valid/ack flag interface. Sits beside `timer` in the peripheral space and shares its 15-bit prescaler convention.

---
 rtl/timer_capture.sv | 127 ++++++++++++
 1 files changed

// File: rtl/timer_capture.sv
// rtl/timer_capture.sv - input-capture unit measuring prescaled intervals between selected edges
module timer_capture (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic [1:0]  edge_sel,
  input  logic [14:0] scale,
  input  logic        sig_in,
  input  logic        ack,
  output logic [15:0] capture,
  output logic        capture_valid,
  output logic        overrun,
  output logic        timeout,
  output logic        measuring
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FIRST = 2'd1;
  localparam logic [1:0] ST_MEASURE    = 2'd2;

  logic [1:0]  state;
  logic        s1, s2, s3;
  logic [14:0] scale_cntr;
  logic [15:0] cntr;
  logic        rise, fall, ev, tick;
  logic        cap_evt, to_evt;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign tick = (scale_cntr == scale);

  // Pick the event edge; the unused encoding behaves like rising.
  always_comb begin
    ev = rise;
    case (edge_sel)
      2'b01:   ev = fall;
      2'b10:   ev = rise | fall;
      default: ev = rise;
    endcase
  end

  // A disarm in the same cycle suppresses both capture and timeout.
  assign cap_evt   = arm && (state == ST_MEASURE) && ev;
  assign to_evt    = arm && (state == ST_MEASURE) && !ev && tick && (cntr == 16'hFFFF);
  assign measuring = (state == ST_MEASURE);

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Sequencing and prescaled interval counting; every edge restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      scale_cntr <= 15'd0;
      cntr       <= 16'd0;
    end else if (!arm) begin
      state      <= ST_IDLE;
      scale_cntr <= 15'd0;
      cntr       <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state      <= ST_WAIT_FIRST;
          scale_cntr <= 15'd0;
          cntr       <= 16'd0;
        end
        ST_WAIT_FIRST, ST_MEASURE: begin
          if (ev || to_evt) begin
            state      <= to_evt ? ST_WAIT_FIRST : ST_MEASURE;
            scale_cntr <= 15'd0;
            cntr       <= 16'd0;
          end else if (tick) begin
            scale_cntr <= 15'd0;
            cntr       <= cntr + 16'd1;
          end else begin
            scale_cntr <= scale_cntr + 15'd1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          scale_cntr <= 15'd0;
          cntr       <= 16'd0;
        end
      endcase
    end
  end

  // Result register and sticky flags; a capture beats a coincident ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      capture       <= 16'd0;
      capture_valid <= 1'b0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      if (cap_evt) begin
        capture       <= cntr + {15'd0, tick};
        capture_valid <= 1'b1;
      end else if (ack) begin
        capture_valid <= 1'b0;
      end

      if (cap_evt && capture_valid && !ack) begin
        overrun <= 1'b1;
      end else if (ack) begin
        overrun <= 1'b0;
      end

      if (to_evt) begin
        timeout <= 1'b1;
      end else if (ack) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule
